// File: rtl/ddr5_phy_pkg.sv
// Shared types and constants for the DDR5 PHY write path: scheduler state
// encoding, burst-length codes, beat counts and the command FIFO entry.
package ddr5_phy_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_GAP   = 2'd2
    } sched_state_t;

    localparam logic [1:0] BL16 = 2'b00;
    localparam logic [1:0] BL8  = 2'b01;

    // Two DQ bits per pin per PHY clock.
    localparam logic [3:0] BEATS_BL16 = 4'd8;
    localparam logic [3:0] BEATS_BL8  = 4'd4;

    localparam logic [3:0] GAP_MAX = 4'd15;

    typedef struct packed {
        logic       crc;
        logic [1:0] bl;
    } wr_cmd_t;

    // Reserved burst-length codes fall back to BL16.
    function automatic logic [1:0] bl_normalize(input logic [1:0] bl);
        return (bl == BL8) ? BL8 : BL16;
    endfunction

    function automatic logic [3:0] bl_beats(input logic [1:0] bl);
        return (bl == BL8) ? BEATS_BL8 : BEATS_BL16;
    endfunction

    function automatic logic [3:0] gap_inc(input logic [3:0] gap);
        return (gap == GAP_MAX) ? GAP_MAX : gap + 4'd1;
    endfunction

endpackage

// File: rtl/ddr5_phy_write_scheduler_if.sv
// Write-command handshake between the command path (master) and the
// write scheduler (slave).
interface ddr5_phy_write_scheduler_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_bl;
    logic       cmd_crc;

    modport master (
        output cmd_valid,
        output cmd_bl,
        output cmd_crc,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_bl,
        input  cmd_crc,
        output cmd_ready
    );

endinterface

// File: rtl/ddr5_phy_cmd_fifo.sv
// Small synchronous FIFO for queued write commands. Read data is the head
// entry, valid whenever the FIFO is not empty; no write-to-read bypass.
module ddr5_phy_cmd_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == ($clog2(DEPTH) + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + ($clog2(DEPTH) + 1)'(1);
                2'b01:   count <= count - ($clog2(DEPTH) + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage.
    always_ff @(posedge clk_i) begin
        // NOTE: storage is deliberately not reset; an entry is only read once count marks it valid.
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/ddr5_phy_write_scheduler.sv
// Drains queued write commands into wr_en bursts for the write datapath FSM,
// enforcing a minimum spacing and flagging back-to-back bursts as interamble.
module ddr5_phy_write_scheduler
    import ddr5_phy_pkg::*;
#(
    parameter int pFIFO_DEPTH = 4,
    parameter int pMIN_GAP    = 2,
    parameter int pIDLE_GAP   = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              enable_i,
    ddr5_phy_write_scheduler_if.slave         cmd,
    output logic                              wr_en_o,
    output logic [1:0]                        burstlength_o,
    output logic                              crc_generate_o,
    output logic                              interamble_o,
    output logic [3:0]                        gap_o,
    output logic                              busy_o
);

    localparam int         CNT_W    = $clog2(pFIFO_DEPTH) + 1;
    localparam logic [3:0] MIN_GAP  = 4'(pMIN_GAP);
    localparam logic [3:0] IDLE_GAP = 4'(pIDLE_GAP);

    sched_state_t     state;
    logic [3:0]       beat_cnt;
    wr_cmd_t          push_cmd;
    wr_cmd_t          pop_cmd;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             push;
    logic             pop;
    logic             fifo_busy_nxt;

    assign cmd.cmd_ready = ~fifo_full & enable_i;
    assign push          = cmd.cmd_valid & cmd.cmd_ready;
    assign push_cmd      = {cmd.cmd_crc, cmd.cmd_bl};

    // Issue from IDLE once the post-idle spacing is met, from GAP once the
    // interamble spacing is met; gap_o counts the low cycles in both cases.
    assign pop = enable_i & ~fifo_empty &
                 (((state == S_IDLE) & (gap_o >= IDLE_GAP)) |
                  ((state == S_GAP)  & (gap_o >= MIN_GAP)));

    // FIFO occupancy after this edge is non-zero.
    assign fifo_busy_nxt = push | (fifo_count > CNT_W'(1)) |
                           ((fifo_count == CNT_W'(1)) & ~pop);

    ddr5_phy_cmd_fifo #(
        .WIDTH ($bits(wr_cmd_t)),
        .DEPTH (pFIFO_DEPTH)
    ) u_cmd_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push    (push),
        .pop     (pop),
        .wr_data (push_cmd),
        .rd_data (pop_cmd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Scheduler FSM with registered burst controls; enable_i low freezes everything.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state          <= S_IDLE;
            beat_cnt       <= '0;
            wr_en_o        <= 1'b0;
            burstlength_o  <= BL16;
            crc_generate_o <= 1'b0;
            interamble_o   <= 1'b0;
            gap_o          <= GAP_MAX;
            busy_o         <= 1'b0;
        end else if (enable_i) begin
            if (pop) begin
                state          <= S_BURST;
                wr_en_o        <= 1'b1;
                beat_cnt       <= bl_beats(pop_cmd.bl);
                burstlength_o  <= bl_normalize(pop_cmd.bl);
                crc_generate_o <= pop_cmd.crc;
                interamble_o   <= (fifo_count > CNT_W'(1));
                gap_o          <= '0;
                busy_o         <= 1'b1;
            end else begin
                case (state)
                    S_BURST: begin
                        interamble_o <= ~fifo_empty;
                        if (beat_cnt == 4'd1) begin
                            wr_en_o <= 1'b0;
                            gap_o   <= gap_inc(gap_o);
                            state   <= fifo_empty ? S_IDLE : S_GAP;
                            busy_o  <= fifo_empty ? fifo_busy_nxt : 1'b1;
                        end else begin
                            beat_cnt <= beat_cnt - 4'd1;
                        end
                    end
                    default: begin
                        gap_o  <= gap_inc(gap_o);
                        busy_o <= (state != S_IDLE) | fifo_busy_nxt;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ddr5_phy_write_scheduler.sv
// Directed bench for ddr5_phy_write_scheduler: expected bursts are queued on
// command acceptance and compared by a monitor as wr_en_o bursts appear.
module tb_ddr5_phy_write_scheduler;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       enable_i;
    logic       wr_en_o;
    logic [1:0] burstlength_o;
    logic       crc_generate_o;
    logic       interamble_o;
    logic [3:0] gap_o;
    logic       busy_o;

    ddr5_phy_write_scheduler_if cmd ();

    ddr5_phy_write_scheduler #(
        .pFIFO_DEPTH (4),
        .pMIN_GAP    (2),
        .pIDLE_GAP   (4)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .enable_i       (enable_i),
        .cmd            (cmd),
        .wr_en_o        (wr_en_o),
        .burstlength_o  (burstlength_o),
        .crc_generate_o (crc_generate_o),
        .interamble_o   (interamble_o),
        .gap_o          (gap_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] bl;
        logic       crc;
        int         high;
    } exp_t;

    exp_t sb[$];
    int   checks       = 0;
    int   errors       = 0;
    int   cyc_no       = 0;
    int   stall_cycles = 0;

    // Cycle index: cycle n is the interval following the n-th rising edge.
    always @(posedge clk) cyc_no++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the falling edge.
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc_no < c) cyc();
    endtask

    // Offer one command; leaves cmd_valid high so the caller can chain commands.
    task automatic send(input logic [1:0] bl, input logic crc, input int freeze);
        exp_t e;
        int   waited = 0;
        cmd.cmd_valid = 1'b1;
        cmd.cmd_bl    = bl;
        cmd.cmd_crc   = crc;
        while (!cmd.cmd_ready && waited < 100) begin
            stall_cycles++;
            cyc();
            waited++;
        end
        check("accept_timeout", cmd.cmd_ready, 1'b1);
        if (cmd.cmd_ready) begin
            e.bl   = (bl == 2'b01) ? 2'b01 : 2'b00;
            e.crc  = crc;
            e.high = ((bl == 2'b01) ? 4 : 8) + freeze;
            sb.push_back(e);
        end
        cyc();
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy_o || wr_en_o) && n < 400) begin
            cyc();
            n++;
        end
        check("idle_timeout", {31'd0, busy_o | wr_en_o}, 0);
        repeat (16) cyc();
    endtask

    // Monitor: pops the expected burst on each wr_en_o rise, checks its length on the fall.
    logic mon_prev = 1'b0;
    int   mon_run  = 0;
    exp_t mon_cur;
    always @(negedge clk) begin
        if (!rst_i) begin
            mon_prev = 1'b0;
            mon_run  = 0;
        end else begin
            if (wr_en_o && !mon_prev) begin
                check("burst_expected", {31'd0, sb.size() != 0}, 1);
                if (sb.size() != 0) begin
                    mon_cur = sb.pop_front();
                    check("burst_bl", burstlength_o, mon_cur.bl);
                    check("burst_crc", crc_generate_o, mon_cur.crc);
                end else begin
                    mon_cur.high = -1;
                end
                mon_run = 1;
            end else if (wr_en_o) begin
                mon_run++;
            end else if (mon_prev) begin
                check("burst_len", mon_run, mon_cur.high);
            end
            mon_prev = wr_en_o;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int               n;
        int               m;
        logic [14:0]      pat;

        rst_i         = 1'b0;
        enable_i      = 1'b1;
        cmd.cmd_valid = 1'b0;
        cmd.cmd_bl    = 2'b00;
        cmd.cmd_crc   = 1'b0;
        cyc();
        cyc();

        // Reset values.
        check("rst_wr_en", wr_en_o, 0);
        check("rst_bl", burstlength_o, 2'b00);
        check("rst_crc", crc_generate_o, 0);
        check("rst_interamble", interamble_o, 0);
        check("rst_gap", gap_o, 15);
        check("rst_busy", busy_o, 0);
        check("rst_ready", cmd.cmd_ready, 1);
        enable_i = 1'b0;
        #1;
        check("rst_ready_disabled", cmd.cmd_ready, 0);
        enable_i = 1'b1;
        rst_i    = 1'b1;
        cyc();

        // Single BL16 command with CRC.
        send(2'b00, 1'b1, 0);
        cmd.cmd_valid = 1'b0;
        check("single_latency", wr_en_o, 0);
        check("single_busy", busy_o, 1);
        cyc();
        for (int i = 0; i < 8; i++) begin
            check("single_wr_en", wr_en_o, 1);
            check("single_gap_burst", gap_o, 0);
            if (i == 0) begin
                check("single_bl", burstlength_o, 2'b00);
                check("single_crc", crc_generate_o, 1);
                check("single_interamble", interamble_o, 0);
            end
            cyc();
        end
        for (int k = 1; k <= 16; k++) begin
            check("single_wr_low", wr_en_o, 0);
            check("single_gap_count", gap_o, (k > 15) ? 15 : k);
            cyc();
        end
        check("single_busy_done", busy_o, 0);
        check("single_crc_held", crc_generate_o, 1);

        // Back-to-back BL8 then BL16.
        wait_idle();
        send(2'b01, 1'b0, 0);
        send(2'b00, 1'b1, 0);
        cmd.cmd_valid = 1'b0;
        pat = 15'b111100111111110;
        for (int idx = 0; idx < 15; idx++) begin
            check("b2b_wr_en", wr_en_o, pat[14-idx]);
            if (idx == 4 || idx == 5) check("b2b_interamble_gap", interamble_o, 1);
            if (idx == 14) check("b2b_interamble_end", interamble_o, 0);
            cyc();
        end

        // Late command after the last beat waits for the idle spacing.
        wait_idle();
        send(2'b01, 1'b1, 0);
        cmd.cmd_valid = 1'b0;
        m = cyc_no - 1 + 5;
        wait_until(m + 1);
        send(2'b00, 1'b0, 0);
        cmd.cmd_valid = 1'b0;
        check("idle_accept_cycle", cyc_no, m + 2);
        wait_until(m + 4);
        check("idle_wr_low", wr_en_o, 0);
        cyc();
        check("idle_wr_rise", wr_en_o, 1);
        check("idle_interamble", interamble_o, 0);

        // FIFO full: six commands offered back to back into a depth-4 FIFO.
        wait_idle();
        stall_cycles = 0;
        send(2'b00, 1'b1, 0);
        send(2'b01, 1'b0, 0);
        send(2'b00, 1'b0, 0);
        send(2'b01, 1'b1, 0);
        send(2'b11, 1'b1, 0);
        send(2'b01, 1'b0, 0);
        cmd.cmd_valid = 1'b0;
        wait_idle();
        check("full_stall_cycles", stall_cycles, 7);
        check("full_all_issued", sb.size(), 0);

        // enable_i low for 3 cycles at beat 3 of a BL16 burst.
        wait_idle();
        send(2'b00, 1'b0, 3);
        cmd.cmd_valid = 1'b0;
        n = cyc_no - 1;
        wait_until(n + 4);
        check("en_beat3", wr_en_o, 1);
        enable_i = 1'b0;
        cyc();
        check("en_frozen_wr_en", wr_en_o, 1);
        check("en_frozen_gap", gap_o, 0);
        check("en_frozen_busy", busy_o, 1);
        check("en_frozen_ready", cmd.cmd_ready, 0);
        cyc();
        cyc();
        enable_i = 1'b1;
        wait_until(n + 12);
        check("en_last_beat", wr_en_o, 1);
        cyc();
        check("en_burst_end", wr_en_o, 0);
        check("en_gap_after", gap_o, 1);

        // Reset mid-burst with a second command queued.
        wait_idle();
        send(2'b00, 1'b1, 0);
        send(2'b01, 1'b0, 0);
        cmd.cmd_valid = 1'b0;
        cyc();
        cyc();
        check("mid_wr_en", wr_en_o, 1);
        check("mid_interamble", interamble_o, 1);
        rst_i = 1'b0;
        #1;
        check("mid_rst_wr_en", wr_en_o, 0);
        check("mid_rst_bl", burstlength_o, 2'b00);
        check("mid_rst_crc", crc_generate_o, 0);
        check("mid_rst_interamble", interamble_o, 0);
        check("mid_rst_gap", gap_o, 15);
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_ready", cmd.cmd_ready, 1);
        sb.delete();
        cyc();
        cyc();
        rst_i = 1'b1;
        repeat (20) cyc();
        check("post_rst_wr_en", wr_en_o, 0);
        check("post_rst_busy", busy_o, 0);
        check("post_rst_gap", gap_o, 15);

        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
